// File: rtl/mdv_pkg.sv
// Shared constants, state encoding and tape-address helper for the Microdrive
// write path.
package mdv_pkg;

    localparam int CLK_SCALER = 36;
    localparam int MAX_WORDS  = 329;
    localparam int AW         = 17;
    localparam int BYTE_TICKS = 8 * (CLK_SCALER + 1);
    localparam int CNT_W      = 9;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_SHIFT,
        ST_COMMIT
    } mdv_wr_state_t;

    // Tape is a loop: the word after the last valid image word is word 0.
    function automatic logic [AW-1:0] next_wptr(input logic [AW-1:0] p,
                                                input logic [AW-1:0] last);
        return (p == last) ? '0 : p + 1'b1;
    endfunction

endpackage

// File: rtl/mdv_bit_timer.sv
// Measures one byte time (eight bit cells) in ce ticks after a start pulse and
// emits a single-clk done pulse on the final tick.
module mdv_bit_timer
    import mdv_pkg::*;
#(
    parameter int P_BYTE_TICKS = BYTE_TICKS
) (
    input  logic clk,
    input  logic reset,
    input  logic ce,
    input  logic i_start,
    input  logic i_abort,
    output logic o_done
);

    localparam int TW = $clog2(P_BYTE_TICKS);

    logic [TW-1:0] r_cnt;
    logic          r_run;

    assign o_done = r_run && ce && (r_cnt == TW'(P_BYTE_TICKS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (i_abort) begin
            r_run <= 1'b0;
        end else if (i_start) begin
            r_cnt <= '0;
            r_run <= 1'b1;
        end else if (o_done) begin
            r_run <= 1'b0;
        end else if (r_run && ce) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mdv_writer.sv
// Microdrive write path: paces CPU transmit bytes at tape rate, packs them into
// 16-bit words and commits them to the cartridge image at the tape position.
module mdv_writer
    import mdv_pkg::*;
#(
    parameter int P_CLK_SCALER = CLK_SCALER,
    parameter int P_MAX_WORDS  = MAX_WORDS
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ce,
    input  logic          download,
    input  logic          sel,
    input  logic          wr_en,
    input  logic          tx_strobe,
    input  logic [7:0]    tx_data,
    input  logic [AW-1:0] rd_addr,
    input  logic [AW-1:0] mdv_end,
    output logic          tx_empty,
    output logic          wr_req,
    output logic [AW-1:0] wr_addr,
    output logic [15:0]   wr_data,
    output logic [1:0]    wr_byteena,
    output logic          overrun,
    output logic          dirty
);

    mdv_wr_state_t r_state, w_state_nx;

    logic             r_tx_empty, r_wr_req, r_overrun, r_dirty, r_hi_vld;
    logic [AW-1:0]    r_wr_addr, r_wptr;
    logic [15:0]      r_wr_data;
    logic [1:0]       r_wr_be;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_byte, r_hi;

    logic w_active, w_room, w_done;
    logic w_start, w_abort, w_accept, w_commit, w_flush, w_arm, w_store_hi;

    assign w_active = sel && wr_en;
    assign w_room   = (r_cnt < CNT_W'(P_MAX_WORDS));

    mdv_bit_timer #(
        .P_BYTE_TICKS(8 * (P_CLK_SCALER + 1))
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .ce     (ce),
        .i_start(w_start),
        .i_abort(w_abort),
        .o_done (w_done)
    );

    always_comb begin
        w_state_nx = r_state;
        w_start    = 1'b0;
        w_abort    = 1'b0;
        w_accept   = 1'b0;
        w_commit   = 1'b0;
        w_flush    = 1'b0;
        w_arm      = 1'b0;
        w_store_hi = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_active && mdv_end != '0) begin
                    w_state_nx = ST_ARMED;
                    w_arm      = 1'b1;
                end
            end
            ST_ARMED: begin
                if (!w_active) begin
                    w_state_nx = ST_IDLE;
                    w_flush    = r_hi_vld;
                end else if (tx_strobe) begin
                    w_state_nx = ST_SHIFT;
                    w_start    = 1'b1;
                    w_accept   = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (!w_active) begin
                    w_state_nx = ST_IDLE;
                    w_abort    = 1'b1;
                end else if (w_done) begin
                    if (r_hi_vld) begin
                        w_state_nx = ST_COMMIT;
                    end else begin
                        w_state_nx = ST_ARMED;
                        w_store_hi = 1'b1;
                    end
                end
            end
            default: begin
                // The word is complete, so it is written even if wr_en just fell.
                w_commit = 1'b1;
                if (!w_active) begin
                    w_state_nx = ST_IDLE;
                end else if (tx_strobe) begin
                    w_state_nx = ST_SHIFT;
                    w_start    = 1'b1;
                    w_accept   = 1'b1;
                end else begin
                    w_state_nx = ST_ARMED;
                end
            end
        endcase
        if (download) begin
            w_state_nx = ST_IDLE;
            w_abort    = 1'b1;
            w_start    = 1'b0;
            w_accept   = 1'b0;
            w_commit   = 1'b0;
            w_flush    = 1'b0;
            w_arm      = 1'b0;
            w_store_hi = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_tx_empty <= 1'b1;
            r_wr_req   <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_wr_be    <= '0;
            r_overrun  <= 1'b0;
            r_dirty    <= 1'b0;
            r_hi_vld   <= 1'b0;
            r_wptr     <= '0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_tx_empty <= (w_state_nx != ST_SHIFT);
            r_wr_req   <= 1'b0;
            if (w_arm) begin
                r_wptr    <= rd_addr;
                r_cnt     <= '0;
                r_overrun <= 1'b0;
            end else if (tx_strobe && !r_tx_empty) begin
                r_overrun <= 1'b1;
            end
            if (w_store_hi) r_hi_vld <= 1'b1;
            if (w_commit) begin
                r_wptr <= next_wptr(r_wptr, mdv_end);
                if (w_room) r_cnt <= r_cnt + 1'b1;
            end
            if ((w_commit || w_flush) && w_room) begin
                r_wr_req  <= 1'b1;
                r_wr_addr <= r_wptr;
                r_wr_data <= {r_hi, w_flush ? 8'h00 : r_byte};
                r_wr_be   <= {1'b1, w_commit};
                r_dirty   <= 1'b1;
            end
            if (w_commit || w_state_nx == ST_IDLE) r_hi_vld <= 1'b0;
            if (download) r_dirty <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept)   r_byte <= tx_data;
        if (w_store_hi) r_hi   <= r_byte;
    end

    assign tx_empty   = r_tx_empty;
    assign wr_req     = r_wr_req;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign wr_byteena = r_wr_be;
    assign overrun    = r_overrun;
    assign dirty      = r_dirty;

endmodule

// File: tb/tb_mdv_writer.sv
// Bench for mdv_writer: a full-rate instance plus a fast-scaler instance for the
// long burst, both checked against a byte-level model of the write path.
module tb_mdv_writer;
    import mdv_pkg::*;

    logic clk = 1'b0, reset = 1'b1, ce = 1'b0;
    logic [1:0]    sel_v = '0, wren_v = '0, dl_v = '0, stb_v = '0;
    logic [7:0]    txd_v [2];
    logic [AW-1:0] rda_v [2];
    logic [AW-1:0] end_v [2];
    logic [1:0]    te_v, req_v, ovr_v, dirty_v;
    logic [AW-1:0] wa_v [2];
    logic [15:0]   wd_v [2];
    logic [1:0]    be_v [2];

    mdv_writer u_dut (
        .clk(clk), .reset(reset), .ce(ce), .download(dl_v[0]), .sel(sel_v[0]),
        .wr_en(wren_v[0]), .tx_strobe(stb_v[0]), .tx_data(txd_v[0]),
        .rd_addr(rda_v[0]), .mdv_end(end_v[0]), .tx_empty(te_v[0]),
        .wr_req(req_v[0]), .wr_addr(wa_v[0]), .wr_data(wd_v[0]),
        .wr_byteena(be_v[0]), .overrun(ovr_v[0]), .dirty(dirty_v[0])
    );

    mdv_writer #(.P_CLK_SCALER(1)) u_fast (
        .clk(clk), .reset(reset), .ce(ce), .download(dl_v[1]), .sel(sel_v[1]),
        .wr_en(wren_v[1]), .tx_strobe(stb_v[1]), .tx_data(txd_v[1]),
        .rd_addr(rda_v[1]), .mdv_end(end_v[1]), .tx_empty(te_v[1]),
        .wr_req(req_v[1]), .wr_addr(wa_v[1]), .wr_data(wd_v[1]),
        .wr_byteena(be_v[1]), .overrun(ovr_v[1]), .dirty(dirty_v[1])
    );

    always #5 clk = ~clk;
    initial forever begin
        @(negedge clk);
        ce = ~ce;
    end

    int tests = 0, fails = 0;
    int m_hv [2], m_wptr [2], m_end [2], m_cnt [2];
    logic [7:0] m_hi [2];
    logic [34:0] q0 [$];
    logic [34:0] q1 [$];
    int ticks_exp [2];
    int lowcnt [2];
    bit skip_tick [2];
    logic prev_te [2];
    int reqs1 = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic void push(input int idx, input int a, input logic [15:0] d,
                                 input logic [1:0] be);
        logic [34:0] e;
        e = {AW'(a), d, be};
        if (idx == 0) q0.push_back(e);
        else q1.push_back(e);
    endfunction

    // A byte that finished shifting: first of a pair is held, second completes a word.
    function automatic void model_byte(input int idx, input logic [7:0] b);
        if (m_hv[idx] == 0) begin
            m_hi[idx] = b;
            m_hv[idx] = 1;
        end else begin
            if (m_cnt[idx] < MAX_WORDS) begin
                push(idx, m_wptr[idx], {m_hi[idx], b}, 2'b11);
                m_cnt[idx]++;
            end
            m_wptr[idx] = (m_wptr[idx] == m_end[idx]) ? 0 : m_wptr[idx] + 1;
            m_hv[idx] = 0;
        end
    endfunction

    function automatic void model_fall(input int idx);
        if (m_hv[idx] != 0 && m_cnt[idx] < MAX_WORDS)
            push(idx, m_wptr[idx], {m_hi[idx], 8'h00}, 2'b10);
        m_hv[idx] = 0;
    endfunction

    always @(posedge clk) begin
        logic [34:0] e;
        #1;
        for (int i = 0; i < 2; i++) begin
            if (req_v[i]) begin
                if (i == 1) reqs1++;
                if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected wr_req[%0d]: addr %0h data %0h, expected no write",
                             i, wa_v[i], wd_v[i]);
                end else begin
                    if (i == 0) e = q0.pop_front();
                    else e = q1.pop_front();
                    chk($sformatf("wr_addr[%0d]", i), 32'(wa_v[i]), 32'(e[34:18]));
                    chk($sformatf("wr_data[%0d]", i), 32'(wd_v[i]), 32'(e[17:2]));
                    chk($sformatf("wr_byteena[%0d]", i), 32'(be_v[i]), 32'(e[1:0]));
                end
            end
            if (!prev_te[i] && ce) lowcnt[i]++;
            if (!prev_te[i] && te_v[i]) begin
                if (!skip_tick[i]) chk($sformatf("tx_empty low ce ticks[%0d]", i), lowcnt[i], ticks_exp[i]);
                lowcnt[i] = 0;
                skip_tick[i] = 0;
            end
            prev_te[i] = te_v[i];
        end
    end

    task automatic wait_empty(input int idx);
        int n;
        n = 0;
        while (te_v[idx] !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) begin
            tests++;
            fails++;
            $display("FAIL wait_tx_empty[%0d]: still busy after %0d cycles, want tx_empty=1", idx, n);
        end
    endtask

    task automatic strobe_raw(input int idx, input logic [7:0] b);
        stb_v[idx] = 1'b1;
        txd_v[idx] = b;
        @(negedge clk);
        stb_v[idx] = 1'b0;
    endtask

    task automatic send(input int idx, input logic [7:0] b);
        wait_empty(idx);
        strobe_raw(idx, b);
        model_byte(idx, b);
    endtask

    task automatic arm(input int idx, input int a, input int e);
        rda_v[idx]  = AW'(a);
        end_v[idx]  = AW'(e);
        sel_v[idx]  = 1'b1;
        wren_v[idx] = 1'b1;
        m_wptr[idx] = a;
        m_end[idx]  = e;
        m_cnt[idx]  = 0;
        m_hv[idx]   = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic disarm(input int idx);
        wait_empty(idx);
        wren_v[idx] = 1'b0;
        model_fall(idx);
        repeat (3) @(negedge clk);
        sel_v[idx] = 1'b0;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int e, a, n;
        ticks_exp[0] = 296;  // 8 * (36 + 1)
        ticks_exp[1] = 16;   // 8 * (1 + 1)
        for (int i = 0; i < 2; i++) begin
            txd_v[i] = '0; rda_v[i] = '0; end_v[i] = '0;
            m_hv[i] = 0; m_wptr[i] = 0; m_end[i] = 0; m_cnt[i] = 0; m_hi[i] = '0;
            lowcnt[i] = 0; skip_tick[i] = 0; prev_te[i] = 1'b1;
        end
        repeat (3) @(negedge clk);
        chk("reset tx_empty", 32'(te_v[0]), 1);
        chk("reset wr_req", 32'(req_v[0]), 0);
        chk("reset wr_addr", 32'(wa_v[0]), 0);
        chk("reset wr_data", 32'(wd_v[0]), 0);
        chk("reset wr_byteena", 32'(be_v[0]), 0);
        chk("reset overrun", 32'(ovr_v[0]), 0);
        chk("reset dirty", 32'(dirty_v[0]), 0);
        reset = 1'b0;
        @(negedge clk);

        arm(0, 100, 2000);
        send(0, 8'h12);
        send(0, 8'h34);
        wait_empty(0);
        repeat (4) @(negedge clk);
        chk("t1 wr_addr", 32'(wa_v[0]), 100);
        chk("t1 wr_data", 32'(wd_v[0]), 32'h1234);
        chk("t1 wr_byteena", 32'(be_v[0]), 2'b11);
        chk("t1 dirty", 32'(dirty_v[0]), 1);
        disarm(0);

        arm(0, 100, 2000);
        send(0, 8'hAA);
        send(0, 8'hBB);
        send(0, 8'hCC);
        disarm(0);
        chk("t2 flush wr_addr", 32'(wa_v[0]), 101);
        chk("t2 flush wr_data", 32'(wd_v[0]), 32'hCC00);
        chk("t2 flush wr_byteena", 32'(be_v[0]), 2'b10);

        arm(0, 50, 50);
        send(0, 8'h01); send(0, 8'h02); send(0, 8'h03); send(0, 8'h04);
        disarm(0);
        chk("t3 wrapped wr_addr", 32'(wa_v[0]), 0);
        chk("t3 wrapped wr_data", 32'(wd_v[0]), 32'h0304);

        arm(0, 10, 2000);
        send(0, 8'h55);
        repeat (20) @(negedge clk);
        strobe_raw(0, 8'h66);
        chk("t4 overrun set", 32'(ovr_v[0]), 1);
        send(0, 8'h77);
        disarm(0);
        chk("t4 word skips dropped byte", 32'(wd_v[0]), 32'h5577);
        chk("t4 overrun sticky", 32'(ovr_v[0]), 1);
        arm(0, 20, 2000);
        chk("t4 overrun cleared on arm", 32'(ovr_v[0]), 0);
        disarm(0);

        rda_v[0] = 17'd5; end_v[0] = '0; sel_v[0] = 1'b1; wren_v[0] = 1'b1;
        repeat (2) @(negedge clk);
        strobe_raw(0, 8'hAB);
        repeat (3) @(negedge clk);
        chk("no image stays idle", 32'(te_v[0]), 1);
        wren_v[0] = 1'b0; sel_v[0] = 1'b0;
        @(negedge clk);

        for (int r = 0; r < 6; r++) begin
            e = int'($urandom_range(4, 3000));
            a = e - int'($urandom_range(0, 3));
            arm(0, a, e);
            n = int'($urandom_range(1, 6));
            for (int j = 0; j < n; j++) begin
                send(0, 8'($urandom));
                if ($urandom_range(0, 3) == 0) begin
                    repeat ($urandom_range(1, 200)) @(negedge clk);
                    strobe_raw(0, 8'($urandom));
                    chk("random overrun", 32'(ovr_v[0]), 1);
                end
            end
            disarm(0);
        end

        reqs1 = 0;
        arm(1, 5, 1000);
        for (int j = 0; j < 700; j++) send(1, 8'($urandom));
        disarm(1);
        repeat (5) @(negedge clk);
        chk("burst wr_req count", reqs1, 329);

        arm(0, 200, 2000);
        send(0, 8'h11);
        wait_empty(0);
        strobe_raw(0, 8'h22);
        repeat (50) @(negedge clk);
        skip_tick[0] = 1;
        #3 reset = 1'b1;
        m_hv[0] = 0; m_hv[1] = 0;
        @(negedge clk);
        chk("t6 reset tx_empty", 32'(te_v[0]), 1);
        chk("t6 reset wr_req", 32'(req_v[0]), 0);
        chk("t6 reset dirty", 32'(dirty_v[0]), 0);
        sel_v[0] = 1'b0; wren_v[0] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        arm(0, 300, 2000);
        send(0, 8'h01); send(0, 8'h02); send(0, 8'h03);
        wait_empty(0);
        strobe_raw(0, 8'h04);
        repeat (50) @(negedge clk);
        chk("t6 dirty before download", 32'(dirty_v[0]), 1);
        skip_tick[0] = 1;
        dl_v[0] = 1'b1;
        m_hv[0] = 0;
        repeat (3) @(negedge clk);
        chk("t6 download tx_empty", 32'(te_v[0]), 1);
        chk("t6 download dirty", 32'(dirty_v[0]), 0);
        chk("t6 download wr_req", 32'(req_v[0]), 0);
        sel_v[0] = 1'b0; wren_v[0] = 1'b0;
        @(negedge clk);
        dl_v[0] = 1'b0;
        repeat (10) @(negedge clk);

        chk("pending writes inst0", q0.size(), 0);
        chk("pending writes inst1", q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
